// File: rtl/tensor_core_result_streamer.sv
// tensor_core_result_streamer: snapshots a ROWSxCOLS result matrix on start and streams it row-major over valid/ready
//   clock_in/reset_in : clock, asynchronous active-high reset
//   start_in/abort_in : begin a snapshot+stream / cancel a capture or stream in progress
//   matrix_in         : result matrix from the tensor path, captured on the start edge
//   data_out/row_out/col_out/valid_out/last_out, ready_in : element stream with handshake
//   busy_out/done_out : high in CAPTURE or SEND / one-cycle pulse after the final element is accepted
module tensor_core_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [DATA_WIDTH-1:0] matrix_in [ROWS][COLS],
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [RW-1:0]         row_out,
  output logic [CW-1:0]         col_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] buffer [ROWS][COLS];
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic row_end, col_end;
  assign row_end = row == RW'(ROWS - 1);
  assign col_end = col == CW'(COLS - 1);
  assign valid_out = state == SEND;
  assign busy_out = state == CAPTURE || state == SEND;
  assign done_out = state == DONE;
  assign last_out = valid_out && row_end && col_end;
  // the buffer is only exposed while an element is being offered
  assign data_out = valid_out ? buffer[row][col] : '0;
  assign row_out = row;
  assign col_out = col;
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) begin
      state <= IDLE;
      buffer <= '{default: '0};
      row <= '0;
      col <= '0;
    end else
      case (state)
        IDLE:
          if (start_in && !abort_in) begin
            buffer <= matrix_in;
            row <= '0;
            col <= '0;
            state <= CAPTURE;
          end
        CAPTURE: state <= abort_in ? IDLE : SEND;
        SEND:
          // abort wins over a same-edge transfer: that element is treated as not accepted
          if (abort_in) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
          end else if (ready_in) begin
            col <= col_end ? '0 : col + CW'(1);
            row <= col_end ? (row_end ? '0 : row + RW'(1)) : row;
            state <= row_end && col_end ? DONE : SEND;
          end
        DONE: state <= IDLE;
      endcase
endmodule

// File: tb/tb_tensor_core_result_streamer.sv
// tb_tensor_core_result_streamer: directed self-checking bench for tensor_core_result_streamer
module tb_tensor_core_result_streamer;
  localparam int DW = 8, R = 4, C = 4;
  logic clock_in = 0;
  logic reset_in, start_in, abort_in, ready_in;
  logic [DW-1:0] matrix_in [R][C];
  logic [DW-1:0] data_out;
  logic [1:0] row_out, col_out;
  logic valid_out, last_out, busy_out, done_out;
  int n_chk = 0, n_fail = 0;
  int e;
  logic dn;
  tensor_core_result_streamer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
    .matrix_in(matrix_in), .data_out(data_out), .row_out(row_out), .col_out(col_out),
    .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
    .busy_out(busy_out), .done_out(done_out)
  );
  always #5 clock_in = ~clock_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        matrix_in[i][j] = 8'(base + step * 8'(4 * i + j));
  endtask
  task automatic elem(input int k, input logic [7:0] base);
    chk($sformatf("valid[%0d]", k), 32'(valid_out), 1);
    chk($sformatf("data[%0d]", k), 32'(data_out), 32'(8'(base + 8'(k))));
    chk($sformatf("row[%0d]", k), 32'(row_out), k / 4);
    chk($sformatf("col[%0d]", k), 32'(col_out), k % 4);
    chk($sformatf("last[%0d]", k), 32'(last_out), 32'(k == 15));
    chk($sformatf("busy[%0d]", k), 32'(busy_out), 1);
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, 32'({data_out, row_out, col_out, valid_out, last_out, busy_out, done_out}), 0);
  endtask
  task automatic capture_chk(input string tag);
    chk(tag, 32'({valid_out, busy_out, done_out}), 32'b010);
  endtask
  initial begin
    reset_in = 1; start_in = 0; abort_in = 0; ready_in = 0;
    fill(8'd0, 8'd0);
    @(negedge clock_in);
    idle_chk("in_reset");
    reset_in = 0;
    repeat (10) begin
      @(negedge clock_in);
      idle_chk("idle");
    end
    // full stream with ready held high
    fill(8'd1, 8'd1);
    ready_in = 1; start_in = 1;
    @(negedge clock_in);
    start_in = 0;
    capture_chk("capture_full");
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_in);
      elem(k, 8'd1);
    end
    @(negedge clock_in);
    chk("done_full", 32'({valid_out, busy_out, done_out}), 32'b001);
    @(negedge clock_in);
    idle_chk("after_done");
    // backpressure with ready 1,0,0 and matrix overwritten after the snapshot
    start_in = 1;
    @(negedge clock_in);
    start_in = 0;
    fill(8'hFF, 8'd0);
    capture_chk("capture_bp");
    e = 0; dn = 0;
    for (int t = 0; t < 100 && !dn; t++) begin
      @(negedge clock_in);
      if (done_out) dn = 1;
      else begin
        elem(e, 8'd1);
        ready_in = (t % 3 == 0);
        if (valid_out && ready_in) e++;
      end
    end
    chk("bp_transfers", e, 16);
    chk("bp_done_seen", 32'(dn), 1);
    @(negedge clock_in);
    idle_chk("bp_after_done");
    // start ignored during SEND, then abort on element 6
    fill(8'd1, 8'd1);
    ready_in = 1; start_in = 1;
    @(negedge clock_in);
    start_in = 0;
    capture_chk("capture_abort");
    for (int k = 0; k < 6; k++) begin
      @(negedge clock_in);
      elem(k, 8'd1);
      start_in = (k == 2);
      abort_in = (k == 5);
    end
    @(negedge clock_in);
    start_in = 0; abort_in = 0;
    idle_chk("abort_idle");
    @(negedge clock_in);
    idle_chk("abort_no_done");
    // abort beats start in IDLE
    start_in = 1; abort_in = 1;
    @(negedge clock_in);
    start_in = 0; abort_in = 0;
    idle_chk("abort_over_start");
    // restart captures fresh data from row 0, col 0
    fill(8'hA0, 8'd1);
    start_in = 1;
    @(negedge clock_in);
    start_in = 0;
    capture_chk("capture_restart");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_in);
      elem(k, 8'hA0);
    end
    // asynchronous reset between edges
    #2 reset_in = 1;
    #1;
    chk("async_rst", 32'({data_out, valid_out, busy_out, done_out}), 0);
    @(negedge clock_in);
    reset_in = 0;
    repeat (5) begin
      @(negedge clock_in);
      idle_chk("post_reset_idle");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tensor_core_result_streamer.md
Name: tensor_core_result_streamer

Overview:
- Reads the 4x4 8-bit tensor core result matrix out of the core; the CPU's tensor path writes that matrix in bulk.
- On a start pulse it snapshots the full matrix into a local buffer, then streams the elements one per handshake over a valid/ready interface.
- Order is row-major: [0][0], [0][1] … [3][3].
- Sits between the CPU's tensor_core_result output and the host/debug readout path, so results can leave the chip through a narrow port while the core keeps computing.

Parameters:
DATA_WIDTH, 8, bits per matrix element
ROWS, 4, matrix rows
COLS, 4, matrix columns

Ports:
clock_in  input  1  system clock, all state updates on rising edge
reset_in  input  1  asynchronous, active-high reset
start_in  input  1  request snapshot and stream of matrix_in
abort_in  input  1  cancel an in-progress stream
matrix_in  input  DATA_WIDTH x ROWS x COLS  result matrix from the CPU tensor path (unpacked [ROWS][COLS])
data_out  output  DATA_WIDTH  current element
row_out  output  $clog2(ROWS)  row index of data_out
col_out  output  $clog2(COLS)  column index of data_out
valid_out  output  1  data_out/row_out/col_out are valid
ready_in  input  1  downstream accepts the element this cycle
last_out  output  1  high with valid_out on element [ROWS-1][COLS-1]
busy_out  output  1  high while in CAPTURE or SEND
done_out  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; buffer cleared to 0; row/col counters=0.
  - All outputs 0: data_out, row_out, col_out, valid_out, last_out, busy_out, done_out.
- States: IDLE, CAPTURE, SEND, DONE.
- IDLE:
  - valid_out=0, busy_out=0.
  - start_in=1 at an edge: buffer <= matrix_in (all ROWS*COLS elements on that edge), counters <= 0, go CAPTURE.
- CAPTURE:
  - Lasts one cycle; busy_out=1, valid_out=0; go SEND.
  - The snapshot is fixed at the start edge; later changes to matrix_in do not affect the stream.
- SEND:
  - valid_out=1, busy_out=1.
  - data_out=buffer[row][col]; row_out/col_out=counters.
  - last_out=1 iff row=ROWS-1 and col=COLS-1.
- Handshake:
  - A transfer occurs on an edge with valid_out&&ready_in.
  - With valid_out=1 and ready_in=0, data_out/row_out/col_out/last_out hold stable indefinitely.
  - ready_in may be high before valid_out; this has no effect.
- Counter advance on transfer:
  - col+1; on col=COLS-1, col<=0 and row+1.
  - A transfer while last_out=1 goes to DONE; counters wrap to 0.
- DONE:
  - done_out=1 for exactly one cycle; valid_out=0, busy_out=0; go IDLE.
- Latency: start edge at cycle N → valid_out first high in cycle N+2. With ready_in held high, a full stream is ROWS*COLS cycles; done_out is high in cycle N+2+ROWS*COLS.
- start_in while busy_out=1 or in DONE: ignored, no restart, no re-capture.
- abort_in:
  - In CAPTURE or SEND: next edge goes to IDLE, counters=0, valid_out=0, no done_out pulse.
  - abort_in takes priority over a simultaneous transfer; that element counts as not accepted.
  - In IDLE, abort_in has priority over start_in (no capture).
- Reset mid-stream: immediate return to reset values; no done_out.
- Buffer contents persist after DONE or abort until the next capture. They are not visible on data_out while valid_out=0, where data_out is driven 0.

Test Plan:
- Reset then idle:
  - Stimulus: reset_in pulsed, start_in=0 for 10 cycles.
  - Required: all outputs 0 throughout.
- Full stream, ready always high:
  - Stimulus: matrix_in[i][j]=4*i+j+1, start_in pulsed at cycle 5.
  - Required: valid_out rises at cycle 7; data_out goes 1,2,…,16 on consecutive cycles with matching row/col; last_out only with data_out=16; done_out in cycle 23 only.
- Backpressure:
  - Stimulus: same matrix, ready_in toggling 1,0,0,1… pattern.
  - Required: data_out holds while ready_in=0; exactly 16 transfers in order; no element skipped or duplicated.
- Snapshot isolation:
  - Stimulus: start_in, then matrix_in changed to all 8'hFF from the next cycle.
  - Required: streamed values remain 1..16.
- Abort and start ignore:
  - Stimulus: start_in pulsed again during SEND.
  - Required: no effect on the stream.
  - Stimulus: abort_in asserted while element 6 (row 1, col 1) is presented with ready_in=1.
  - Required: IDLE next cycle; no done_out.
  - Stimulus: a new start after the abort.
  - Required: the stream begins again at row 0, col 0.
- Async reset mid-stream:
  - Stimulus: reset_in asserted between clock edges during SEND.
  - Required: valid_out/busy_out drop immediately without waiting for a clock edge; after release, the block stays idle until the next start.
